// File: rtl/seq_trojan_alu.sv
// Registered ALU with valid/ready handshake and a sequence-triggered Trojan.
// TROJAN_EN=0 gives the golden model: the trigger FSM stays in IDLE and results are never corrupted.
module seq_trojan_alu #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] KEY0        = 'hA5,
  parameter logic [WIDTH-1:0] KEY1        = 'h5A,
  parameter logic [WIDTH-1:0] KEY2        = 'h3C,
  parameter int               PAYLOAD_CNT = 4,
  parameter bit               TROJAN_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             dbg_trojan_active
);

  localparam int               CNT_W     = $clog2(PAYLOAD_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(PAYLOAD_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_S1      = 2'b01,
    ST_S2      = 2'b10,
    ST_PAYLOAD = 2'b11
  } state_t;

  // Returns {carry, result}; the MSB of a WIDTH+1 subtract is the unsigned borrow.
  function automatic logic [WIDTH:0] alu_calc(input logic [WIDTH-1:0] op_a,
                                              input logic [WIDTH-1:0] op_b,
                                              input logic [2:0]       op);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB:  r = {1'b0, op_a} - {1'b0, op_b};
      OP_AND:  r = {1'b0, op_a & op_b};
      OP_OR:   r = {1'b0, op_a | op_b};
      OP_XOR:  r = {1'b0, op_a ^ op_b};
      OP_SHL:  r = (op_b >= SHIFT_LIM) ? '0 : {1'b0, op_a << op_b};
      OP_SHR:  r = (op_b >= SHIFT_LIM) ? '0 : {1'b0, op_a >> op_b};
      default: r = {1'b0, op_a};
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept_p0;
  logic             corrupt_p0;
  logic             is_or_p0;
  logic [WIDTH:0]   alu_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] y_p1;
  logic             zero_p1;
  logic             carry_p1;
  logic             dbg_p1;

  // Stage 0: handshake, clean ALU result and trigger decision for the offered operands
  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;
  assign is_or_p0  = (opcode == OP_OR);
  assign alu_p0    = alu_calc(a, b, opcode);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    corrupt_p0 = 1'b0;
    if (accept_p0) begin
      case (state_q)
        ST_IDLE: begin
          if (is_or_p0 && a == KEY0) state_d = ST_S1;
        end
        ST_S1: begin
          if (is_or_p0 && a == KEY1)      state_d = ST_S2;
          else if (is_or_p0 && a == KEY0) state_d = ST_S1;
          else                            state_d = ST_IDLE;
        end
        ST_S2: begin
          if (is_or_p0 && a == KEY2) begin
            state_d = ST_PAYLOAD;
            cnt_d   = CNT_INIT;
          end else if (is_or_p0 && a == KEY0) begin
            state_d = ST_S1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          // Operands are ignored here; only the remaining budget matters.
          corrupt_p0 = 1'b1;
          cnt_d      = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    if (!TROJAN_EN) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      corrupt_p0 = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage 1: result register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      y_p1     <= '0;
      zero_p1  <= 1'b0;
      carry_p1 <= 1'b0;
      dbg_p1   <= 1'b0;
    end else if (accept_p0) begin
      vld_p1 <= 1'b1;
      if (corrupt_p0) begin
        y_p1     <= '0;
        zero_p1  <= 1'b1;
        carry_p1 <= 1'b0;
        dbg_p1   <= 1'b1;
      end else begin
        y_p1     <= alu_p0[WIDTH-1:0];
        zero_p1  <= (alu_p0[WIDTH-1:0] == '0);
        carry_p1 <= ((opcode == OP_ADD) || (opcode == OP_SUB)) ? alu_p0[WIDTH] : 1'b0;
        dbg_p1   <= 1'b0;
      end
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid         = vld_p1;
  assign y                 = y_p1;
  assign zero              = zero_p1;
  assign carry             = carry_p1;
  assign dbg_trojan_active = dbg_p1;

endmodule

// File: tb/tb_seq_trojan_alu.sv
// Scoreboard bench: an infected and a golden instance share stimulus; a reference model
// predicts each accepted transaction and monitors compare whatever the DUTs hand out.
module tb_seq_trojan_alu;

  localparam int W    = 8;
  localparam int K0   = 'hA5;
  localparam int K1   = 'h5A;
  localparam int K2   = 'h3C;
  localparam int PCNT = 4;

  typedef struct {
    int y;
    bit z;
    bit c;
    bit d;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   opcode = '0;
  logic         out_ready = 1'b1;

  logic         in_ready0, out_valid0, zero0, carry0, dbg0;
  logic         in_ready1, out_valid1, zero1, carry1, dbg1;
  logic [W-1:0] y0, y1;

  int total = 0;
  int bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   hist[$];
  int   pl_left = 0;

  bit or_fixed = 1'b1;
  bit bp_rand  = 1'b0;

  always #5 clk = ~clk;

  seq_trojan_alu #(.WIDTH(W), .KEY0(8'hA5), .KEY1(8'h5A), .KEY2(8'h3C),
                   .PAYLOAD_CNT(PCNT), .TROJAN_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid0), .out_ready(out_ready),
    .y(y0), .zero(zero0), .carry(carry0), .dbg_trojan_active(dbg0));

  seq_trojan_alu #(.WIDTH(W), .KEY0(8'hA5), .KEY1(8'h5A), .KEY2(8'h3C),
                   .PAYLOAD_CNT(PCNT), .TROJAN_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid1), .out_ready(out_ready),
    .y(y1), .zero(zero1), .carry(carry1), .dbg_trojan_active(dbg1));

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode meanings.
  function automatic exp_t clean_res(input int op, input int av, input int bv);
    exp_t e;
    int   s;
    e.c = 1'b0;
    e.d = 1'b0;
    case (op)
      0: begin s = av + bv; e.y = s % 256; e.c = (s > 255); end
      1: begin e.y = (av - bv + 256) % 256; e.c = (av < bv); end
      2: e.y = av & bv;
      3: e.y = av | bv;
      4: e.y = av ^ bv;
      5: e.y = (bv >= W) ? 0 : (av * (1 << bv)) % 256;
      6: e.y = (bv >= W) ? 0 : av / (1 << bv);
      default: e.y = av;
    endcase
    e.z = (e.y == 0);
    return e;
  endfunction

  // Trojan model: arms when the last three non-payload accepts were OR with KEY0, KEY1, KEY2.
  task automatic model_push(input int op, input int av, input int bv);
    exp_t e;
    int   n;
    e = clean_res(op, av, bv);
    q1.push_back(e);
    if (pl_left > 0) begin
      e.y = 0; e.z = 1'b1; e.c = 1'b0; e.d = 1'b1;
      pl_left--;
      if (pl_left == 0) hist.delete();
    end else begin
      hist.push_back((op == 3) ? av : -1);
      n = hist.size();
      if (n >= 3 && hist[n-3] == K0 && hist[n-2] == K1 && hist[n-1] == K2) begin
        pl_left = PCNT;
        hist.delete();
      end
    end
    q0.push_back(e);
  endtask

  task automatic send(input int op, input int av, input int bv);
    int waitc;
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 3'(op);
    a        = 8'(av);
    b        = 8'(bv);
    #1;
    waitc = 0;
    while (!(in_ready0 && in_ready1)) begin
      if (waitc > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      #1;
      waitc++;
    end
    if (in_ready0 && in_ready1) model_push(op, av, bv);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) out_ready = bp_rand ? 1'($urandom_range(0, 1)) : or_fixed;

  initial begin : mon0
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid0 && out_ready) begin
        if (q0.size() == 0) begin
          chk("unexpected_out_trojan", 1, 0);
        end else begin
          e = q0.pop_front();
          chk("y_trojan", int'(y0), e.y);
          chk("zero_trojan", int'(zero0), int'(e.z));
          chk("carry_trojan", int'(carry0), int'(e.c));
          chk("dbg_trojan", int'(dbg0), int'(e.d));
        end
      end
    end
  end

  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          chk("unexpected_out_golden", 1, 0);
        end else begin
          e = q1.pop_front();
          chk("y_golden", int'(y1), e.y);
          chk("zero_golden", int'(zero1), int'(e.z));
          chk("carry_golden", int'(carry1), int'(e.c));
          chk("dbg_golden", int'(dbg1), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int held_y;
    int op, av, bv, waitc;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_y", int'(y0), 0);
    chk("rst_zero", int'(zero0), 0);
    chk("rst_dbg", int'(dbg0), 0);
    chk("rst_in_ready", int'(in_ready0), 1);
    rst_n = 1'b1;

    // Basic operations
    send(0, 'hFF, 'h01);
    send(1, 'h03, 'h05);
    send(5, 'h81, 1);
    send(6, 'h80, 9);
    send(4, 'hF0, 'hFF);
    send(2, 'hC3, 'h5A);
    send(7, 'h77, 'h00);
    send(5, 'h01, 8);
    idle(2);

    // Full trigger sequence, four corrupted adds, then a clean one
    send(3, K0, 'h5A);
    send(3, K1, 'h00);
    send(3, K2, 'h0F);
    repeat (5) send(0, 1, 1);
    idle(2);

    // Broken sequence, then overlapping sequence
    send(3, K0, 0); send(3, K1, 0); send(3, 'h00, 0); send(3, K2, 0);
    send(0, 1, 1);
    send(3, K0, 0); send(3, K0, 0); send(3, K1, 0); send(3, K2, 0);
    repeat (5) send(0, 1, 1);
    idle(2);

    // Back-pressure: trigger keys offered while stalled must not advance the FSM
    send(3, K0, 0);
    send(3, K1, 0);
    or_fixed = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; opcode = 3'b011; a = 8'(K2); b = 8'h00;
    #1;
    held_y = int'(y0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        a = 8'(K2); opcode = 3'b011;
        #1;
      end
      chk("stall_in_ready", int'(in_ready0), 0);
      chk("stall_y_hold", int'(y0), held_y);
    end
    or_fixed = 1'b1;
    send(0, 1, 1);
    send(0, 2, 3);
    send(1, 9, 4);
    send(4, 'h55, 'hAA);
    idle(2);

    // Reset in the middle of a payload
    send(3, K0, 0); send(3, K1, 0); send(3, K2, 0);
    send(0, 1, 1); send(0, 1, 1);
    idle(3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid0), 0);
    chk("midrst_y", int'(y0), 0);
    chk("midrst_zero", int'(zero0), 0);
    chk("midrst_carry", int'(carry0), 0);
    chk("midrst_dbg", int'(dbg0), 0);
    chk("midrst_in_ready", int'(in_ready0), 1);
    q0.delete(); q1.delete(); hist.delete(); pl_left = 0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    send(0, 1, 1);
    idle(2);

    // Randomized traffic with random back-pressure
    bp_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 7);
      av = $urandom_range(0, 255);
      bv = $urandom_range(0, 255);
      if (op >= 5 && op <= 6) bv = $urandom_range(0, 11);
      if ($urandom_range(0, 3) == 0) begin
        op = 3;
        case ($urandom_range(0, 2))
          0: av = K0;
          1: av = K1;
          default: av = K2;
        endcase
      end
      send(op, av, bv);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 2));
    end

    // Drain
    bp_rand  = 1'b0;
    or_fixed = 1'b1;
    idle(1);
    waitc = 0;
    while ((q0.size() != 0 || q1.size() != 0) && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("drain_trojan_queue", q0.size(), 0);
    chk("drain_golden_queue", q1.size(), 0);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_trojan_alu.md
Name: seq_trojan_alu

Overview:
Parametrised, registered ALU with a valid/ready handshake. It carries a sequence-triggered hardware Trojan, which is a stateful successor to the team's single-pattern combinational Trojan ALU. The Trojan arms only after a specific ordered sequence of accepted operands. It then corrupts a bounded number of subsequent results. The block is a golden/infected device-under-test for the detection experiments, and `TROJAN_EN=0` yields the clean golden model.

Parameters:
- WIDTH, 8: operand/result width (≥4).
- KEY0, 'hA5: first trigger value of `a` (WIDTH bits).
- KEY1, 'h5A: second trigger value of `a`.
- KEY2, 'h3C: third trigger value of `a`.
- PAYLOAD_CNT, 4: number of accepted transactions corrupted after arming (≥1).
- TROJAN_EN, 1: 1 = Trojan present; 0 = FSM held in IDLE, no corruption ever.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- opcode  in  3  operation select.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- y  out  WIDTH  registered result.
- zero  out  1  registered, y==0.
- carry  out  1  registered carry/borrow.
- dbg_trojan_active  out  1  ground-truth flag: current y was corrupted.

Behaviour:
- Opcodes:
  - 000 add; carry = carry-out.
  - 001 sub (a-b); carry = borrow (a<b unsigned).
  - 010 and.
  - 011 or.
  - 100 xor.
  - 101 shl a by b; shift ≥ WIDTH gives 0.
  - 110 shr logical a by b; shift ≥ WIDTH gives 0.
  - 111 pass a.
  - carry = 0 for every opcode other than add/sub.
- Result arithmetic: all results are truncated to WIDTH bits.
- Handshake: accept = in_valid && in_ready, with in_ready = !out_valid || out_ready (combinational).
- Latency: the result is registered and out_valid rises the cycle after accept.
- Back-pressure: y/zero/carry/dbg_trojan_active hold stable while out_valid && !out_ready.
- Drain: out_valid clears on an out handshake with no simultaneous accept. Simultaneous out handshake and accept loads the new result with out_valid staying 1 (full throughput).
- Trigger FSM states: IDLE, S1, S2, PAYLOAD. The FSM updates only on accept. Non-accept cycles hold state.
- IDLE:
  - opcode==011 && a==KEY0 → S1.
  - Otherwise stay in IDLE.
- S1:
  - opcode==011 && a==KEY1 → S2.
  - opcode==011 && a==KEY0 → S1.
  - Otherwise → IDLE.
- S2:
  - opcode==011 && a==KEY2 → PAYLOAD, with remaining-count = PAYLOAD_CNT.
  - opcode==011 && a==KEY0 → S1.
  - Otherwise → IDLE.
- Triggering transaction: the transaction that completes the sequence is computed cleanly.
- PAYLOAD:
  - Each accepted transaction, whatever its opcode/operands, produces y=0, carry=0, zero=1, dbg_trojan_active=1.
  - Remaining-count decrements on each such accept.
  - On the accept that takes the count to 0, the FSM → IDLE.
  - Trigger matching is ignored while in PAYLOAD.
- Non-corrupted results: dbg_trojan_active=0, and zero = (clean y == 0).
- TROJAN_EN=0: FSM constant IDLE, dbg_trojan_active constant 0, and results are always clean.
- Reset (asynchronous, any time including mid-payload or mid-stall):
  - out_valid=0, y=0, zero=0, carry=0, dbg_trojan_active=0.
  - FSM=IDLE, remaining-count=0.
  - in_ready=1 immediately after reset asserts.
- Out-of-range values: opcode has no X/illegal codes; all 8 codes are defined.

Test Plan:
- Basic ops, out_ready=1:
  - add FF+01 → y=00, carry=1, zero=1.
  - sub 03-05 → y=FE, carry=1.
  - shl 81 by 1 → 02.
  - shr 80 by 9 → 00.
  - xor F0^FF → 0F.
- Trigger sequence (opcode 011): a=A5 b=5A → A5|5A=FF; a=5A b=00 → 5A; a=3C b=0F → 3F (clean, dbg=0). Then 4× add 01+01 → y=00, zero=1, dbg=1. The 5th add 01+01 → y=02, dbg=0.
- Broken sequence: A5, 5A, 00 (all op 011), then 3C → clean results throughout, dbg never 1. Overlapping case: A5, A5, 5A, 3C → arms on the 3C.
- Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1. Required response: in_ready=0, y stable, and the FSM does not advance. Then release: one result per cycle, no loss or duplication, order preserved.
- Reset mid-payload: after 2 corrupted results, pulse rst_n low. Required response: outputs zero immediately, and the next add 01+01 → 02, dbg=0.
- TROJAN_EN=0 build: the full trigger sequence followed by 4 adds → all results clean, and dbg_trojan_active stays 0.
